mode_keys_scanner: RTL and testbench

- Front-panel input side of the tape-mode indicator path.
- Samples two active-low pushbuttons, synchronises and debounces them, and turns each confirmed press into a mode-ID step.
  - LOAD key steps the load mode ID.
  - SAVE key steps the save mode ID.
- The two mode IDs feed the tape load/save logic and the 4-digit seven-segment indicator.

---
 rtl/mode_keys_scanner.sv | 218 +++++++++++++++++++++
 tb/tb_mode_keys_scanner.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/mode_keys_scanner.sv
// mode_keys_scanner
//   Front-panel key scanner for the tape-mode indicator path. It synchronises
//   and debounces the active-low LOAD and SAVE pushbuttons. Each confirmed
//   press steps the matching mode ID, and the ID wraps at MODES-1. A press on
//   one key while the other key is down is a combo: it clears both IDs to 0.
//
// Ports
//   i_clock          system clock (56.84 MHz)
//   i_reset          asynchronous reset, active-high
//   i_key_load_n     LOAD pushbutton, active-low, asynchronous to i_clock
//   i_key_save_n     SAVE pushbutton, active-low, asynchronous to i_clock
//   o_load_mode_id   load mode: 0 = normal_wav, 1 = turbo_tap
//   o_save_mode_id   save mode: 0 = normal_wav, 1 = turbo_tap, 2 = normal_tap
//   o_mode_changed   one-cycle pulse, coincident with a new ID write
//
// Build option
//   MODE_KEYS_AUTOREPEAT_EN : when defined, a held key auto-repeats.
//     The first repeat comes REPEAT_DELAY_CYCLES after the press event.
//     Later repeats follow every REPEAT_PERIOD_CYCLES.
//     With the macro undefined, each press gives exactly one step.
//
// Debug visibility: key_state_q holds both per-key FSM states.
//   Bit field [0] is LOAD and bit field [1] is SAVE.
//   Encoding: 0 IDLE, 1 PRESS_DB, 2 HELD, 3 RELEASE_DB.
module mode_keys_scanner #(
    parameter int DEBOUNCE_CYCLES      = 568400,
    parameter int LOAD_MODES           = 2,
    parameter int SAVE_MODES           = 3,
    parameter int REPEAT_DELAY_CYCLES  = 28420000,
    parameter int REPEAT_PERIOD_CYCLES = 11368000
) (
    input  logic       i_clock,
    input  logic       i_reset,
    input  logic       i_key_load_n,
    input  logic       i_key_save_n,
    output logic [1:0] o_load_mode_id,
    output logic [1:0] o_save_mode_id,
    output logic       o_mode_changed
);

    localparam logic [1:0] ST_IDLE       = 2'd0;
    localparam logic [1:0] ST_PRESS_DB   = 2'd1;
    localparam logic [1:0] ST_HELD       = 2'd2;
    localparam logic [1:0] ST_RELEASE_DB = 2'd3;

    // One counter width serves both the debounce and the hold counters.
    localparam int MAX_DR  = (DEBOUNCE_CYCLES > REPEAT_DELAY_CYCLES) ? DEBOUNCE_CYCLES : REPEAT_DELAY_CYCLES;
    localparam int MAX_CYC = (MAX_DR > REPEAT_PERIOD_CYCLES) ? MAX_DR : REPEAT_PERIOD_CYCLES;
    localparam int CW      = $clog2(MAX_CYC + 1);

    localparam logic [CW-1:0] DB_LAST   = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [1:0]    LOAD_LAST = 2'(LOAD_MODES - 1);
    localparam logic [1:0]    SAVE_LAST = 2'(SAVE_MODES - 1);

    // Index 0 = LOAD key, index 1 = SAVE key.
    logic [1:0]         sync1_q, sync1_d;
    logic [1:0]         sync2_q, sync2_d;
    logic [1:0]         key_k;
    logic [1:0][1:0]    key_state_q, key_state_d;
    logic [1:0][CW-1:0] db_cnt_q, db_cnt_d;
    logic [1:0]         press_evt;
    logic [1:0]         rep_evt;
    logic [1:0]         busy;
    logic [1:0]         step_evt;
    logic               clear_all;
    logic [1:0]         load_id_q, load_id_d;
    logic [1:0]         save_id_q, save_id_d;
    logic               changed_q, changed_d;

    // Two-flop synchroniser, then invert to an active-high "pressed" level.
    assign sync1_d = {i_key_save_n, i_key_load_n};
    assign sync2_d = sync1_q;
    assign key_k   = ~sync2_q;

    // Per-key debounce FSM. The press event is a Mealy output on the
    // PRESS_DB -> HELD transition, so the ID register updates one cycle later.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            key_state_d[i[0]] = key_state_q[i[0]];
            db_cnt_d[i[0]]    = db_cnt_q[i[0]];
            press_evt[i[0]]   = 1'b0;
            busy[i[0]]        = (key_state_q[i[0]] == ST_HELD) || (key_state_q[i[0]] == ST_RELEASE_DB);
            case (key_state_q[i[0]])
                ST_IDLE: begin
                    db_cnt_d[i[0]] = '0;
                    if (key_k[i[0]]) key_state_d[i[0]] = ST_PRESS_DB;
                end
                ST_PRESS_DB: begin
                    if (!key_k[i[0]]) begin
                        key_state_d[i[0]] = ST_IDLE;
                        db_cnt_d[i[0]]    = '0;
                    end else if (db_cnt_q[i[0]] == DB_LAST) begin
                        key_state_d[i[0]] = ST_HELD;
                        db_cnt_d[i[0]]    = '0;
                        press_evt[i[0]]   = 1'b1;
                    end else begin
                        db_cnt_d[i[0]] = db_cnt_q[i[0]] + CW'(1);
                    end
                end
                ST_HELD: begin
                    if (!key_k[i[0]]) begin
                        key_state_d[i[0]] = ST_RELEASE_DB;
                        db_cnt_d[i[0]]    = '0;
                    end
                end
                default: begin // ST_RELEASE_DB
                    if (key_k[i[0]]) begin
                        key_state_d[i[0]] = ST_HELD;
                        db_cnt_d[i[0]]    = '0;
                    end else if (db_cnt_q[i[0]] == DB_LAST) begin
                        key_state_d[i[0]] = ST_IDLE;
                        db_cnt_d[i[0]]    = '0;
                    end else begin
                        db_cnt_d[i[0]] = db_cnt_q[i[0]] + CW'(1);
                    end
                end
            endcase
        end
    end

    // Combo: both presses land together, or one key is pressed while the
    // other key is still down (HELD or still debouncing its release).
    assign clear_all = (press_evt[0] & (press_evt[1] | busy[1])) | (press_evt[1] & busy[0]);

`ifdef MODE_KEYS_AUTOREPEAT_EN
    localparam logic [CW-1:0] DLY_LAST = CW'(REPEAT_DELAY_CYCLES - 1);
    localparam logic [CW-1:0] PER_LAST = CW'(REPEAT_PERIOD_CYCLES - 1);

    logic [1:0][CW-1:0] hold_cnt_q, hold_cnt_d;
    logic [1:0]         rep_phase_q, rep_phase_d;  // 0: initial delay, 1: periodic
    logic               combo_lock_q, combo_lock_d;

    // Hold counters run only while a key stays in HELD, the other key is up,
    // and no combo is pending. Any interruption restarts the initial delay.
    always_comb begin
        combo_lock_d = combo_lock_q;
        if (clear_all) begin
            combo_lock_d = 1'b1;
        end else if (key_state_q[0] == ST_IDLE && key_state_q[1] == ST_IDLE) begin
            combo_lock_d = 1'b0;
        end
        for (int i = 0; i < 2; i++) begin
            hold_cnt_d[i[0]]  = hold_cnt_q[i[0]];
            rep_phase_d[i[0]] = rep_phase_q[i[0]];
            rep_evt[i[0]]     = 1'b0;
            if (key_state_q[i[0]] != ST_HELD || key_state_d[i[0]] != ST_HELD ||
                combo_lock_q || busy[~i[0]]) begin
                hold_cnt_d[i[0]]  = '0;
                rep_phase_d[i[0]] = 1'b0;
            end else if (hold_cnt_q[i[0]] == (rep_phase_q[i[0]] ? PER_LAST : DLY_LAST)) begin
                hold_cnt_d[i[0]]  = '0;
                rep_phase_d[i[0]] = 1'b1;
                rep_evt[i[0]]     = 1'b1;
            end else begin
                hold_cnt_d[i[0]] = hold_cnt_q[i[0]] + CW'(1);
            end
        end
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            hold_cnt_q   <= '0;
            rep_phase_q  <= '0;
            combo_lock_q <= 1'b0;
        end else begin
            hold_cnt_q   <= hold_cnt_d;
            rep_phase_q  <= rep_phase_d;
            combo_lock_q <= combo_lock_d;
        end
    end
`else
    assign rep_evt = 2'b00;
`endif

    assign step_evt = press_evt | rep_evt;

    // A clear takes priority over any step, so each register sees at most one
    // write per cycle and only one change pulse is raised.
    always_comb begin
        load_id_d = load_id_q;
        save_id_d = save_id_q;
        changed_d = 1'b0;
        if (clear_all) begin
            load_id_d = 2'd0;
            save_id_d = 2'd0;
            changed_d = 1'b1;
        end else begin
            if (step_evt[0]) load_id_d = (load_id_q == LOAD_LAST) ? 2'd0 : load_id_q + 2'd1;
            if (step_evt[1]) save_id_d = (save_id_q == SAVE_LAST) ? 2'd0 : save_id_q + 2'd1;
            changed_d = |step_evt;
        end
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            sync1_q     <= 2'b11;
            sync2_q     <= 2'b11;
            key_state_q <= {ST_IDLE, ST_IDLE};
            db_cnt_q    <= '0;
            load_id_q   <= 2'd0;
            save_id_q   <= 2'd0;
            changed_q   <= 1'b0;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            key_state_q <= key_state_d;
            db_cnt_q    <= db_cnt_d;
            load_id_q   <= load_id_d;
            save_id_q   <= save_id_d;
            changed_q   <= changed_d;
        end
    end

    assign o_load_mode_id = load_id_q;
    assign o_save_mode_id = save_id_q;
    assign o_mode_changed = changed_q;

endmodule

// File: tb/tb_mode_keys_scanner.sv
// Directed bench for mode_keys_scanner (DEBOUNCE_CYCLES=4, repeat 20/8).
// Inputs change on the falling clock edge and outputs are sampled there too.
// With a 4-cycle debounce, an ID changes 7 falling edges after the pin edge.
module tb_mode_keys_scanner;

    logic       clk = 1'b0;
    logic       rst;
    logic       key_load_n;
    logic       key_save_n;
    logic [1:0] load_id;
    logic [1:0] save_id;
    logic       changed;

    int total = 0;
    int bad   = 0;
    int pulse_cnt = 0;

    mode_keys_scanner #(
        .DEBOUNCE_CYCLES      (4),
        .LOAD_MODES           (2),
        .SAVE_MODES           (3),
        .REPEAT_DELAY_CYCLES  (20),
        .REPEAT_PERIOD_CYCLES (8)
    ) dut (
        .i_clock        (clk),
        .i_reset        (rst),
        .i_key_load_n   (key_load_n),
        .i_key_save_n   (key_save_n),
        .o_load_mode_id (load_id),
        .o_save_mode_id (save_id),
        .o_mode_changed (changed)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    // Pulse counter, sampled 2 time units after each rising edge.
    always @(posedge clk) begin
        #2;
        if (changed === 1'b1) pulse_cnt++;
    end

    // ---------------- drivers ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Clean press of one key for low_cycles, then wait for the release to settle.
    task automatic press(input bit is_save, input int low_cycles);
        if (is_save) key_save_n = 1'b0; else key_load_n = 1'b0;
        tick(low_cycles);
        if (is_save) key_save_n = 1'b1; else key_load_n = 1'b1;
        tick(12);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1; key_load_n = 1'b1; key_save_n = 1'b1;
        tick(3);
        total++; if (load_id !== 2'd0) begin bad++; $display("FAIL reset_load got=%0d want=0", load_id); end
        total++; if (save_id !== 2'd0) begin bad++; $display("FAIL reset_save got=%0d want=0", save_id); end
        total++; if (changed !== 1'b0) begin bad++; $display("FAIL reset_changed got=%0b want=0", changed); end
        rst = 1'b0;
        tick(10);
        total++; if (pulse_cnt !== 0) begin bad++; $display("FAIL idle_pulses got=%0d want=0", pulse_cnt); end
    endtask

    task automatic test_save_wrap();
        logic [1:0] exp_ids [3];
        logic [1:0] prev;
        int base;
        exp_ids = '{2'd1, 2'd2, 2'd0};
        for (int k = 0; k < 3; k++) begin
            prev = (k == 0) ? 2'd0 : exp_ids[k-1];
            base = pulse_cnt;
            key_save_n = 1'b0;
            tick(6);
            total++; if (save_id !== prev) begin bad++; $display("FAIL wrap_early[%0d] got=%0d want=%0d", k, save_id, prev); end
            tick(1);
            total++; if (save_id !== exp_ids[k]) begin bad++; $display("FAIL wrap_step[%0d] got=%0d want=%0d", k, save_id, exp_ids[k]); end
            total++; if (changed !== 1'b1) begin bad++; $display("FAIL wrap_pulse[%0d] got=%0b want=1", k, changed); end
            tick(1);
            total++; if (changed !== 1'b0) begin bad++; $display("FAIL wrap_pulse_end[%0d] got=%0b want=0", k, changed); end
            tick(12);
            key_save_n = 1'b1;
            tick(12);
            total++; if (pulse_cnt - base !== 1) begin bad++; $display("FAIL wrap_count[%0d] got=%0d want=1", k, pulse_cnt - base); end
            total++; if (load_id !== 2'd0) begin bad++; $display("FAIL wrap_load[%0d] got=%0d want=0", k, load_id); end
        end
    endtask

    task automatic test_async_reset();
        press(1'b1, 20);
        press(1'b1, 20);
        total++; if (save_id !== 2'd2) begin bad++; $display("FAIL ar_setup got=%0d want=2", save_id); end
        #2 rst = 1'b1;
        #1;
        total++; if (save_id !== 2'd0) begin bad++; $display("FAIL ar_save got=%0d want=0", save_id); end
        total++; if (changed !== 1'b0) begin bad++; $display("FAIL ar_changed got=%0b want=0", changed); end
        tick(1);
        rst = 1'b0;
        tick(2);
    endtask

    task automatic test_glitch_bounce();
        int base;
        base = pulse_cnt;
        key_load_n = 1'b0; tick(3); key_load_n = 1'b1;
        tick(15);
        total++; if (load_id !== 2'd0) begin bad++; $display("FAIL glitch_load got=%0d want=0", load_id); end
        total++; if (pulse_cnt !== base) begin bad++; $display("FAIL glitch_pulses got=%0d want=%0d", pulse_cnt, base); end
        // 10-cycle press with a 2-cycle high bounce starting at cycle 2.
        key_load_n = 1'b0; tick(2);
        key_load_n = 1'b1; tick(2);
        key_load_n = 1'b0; tick(6);
        key_load_n = 1'b1; tick(1);
        total++; if (load_id !== 2'd1) begin bad++; $display("FAIL bounce_step got=%0d want=1", load_id); end
        total++; if (changed !== 1'b1) begin bad++; $display("FAIL bounce_pulse got=%0b want=1", changed); end
        tick(15);
        total++; if (pulse_cnt - base !== 1) begin bad++; $display("FAIL bounce_count got=%0d want=1", pulse_cnt - base); end
        total++; if (load_id !== 2'd1) begin bad++; $display("FAIL bounce_final got=%0d want=1", load_id); end
    endtask

    task automatic test_combo_hold();
        int base;
        press(1'b0, 20);  // load 1 -> 0
        press(1'b1, 20);  // save 0 -> 1
        total++; if (load_id !== 2'd0 || save_id !== 2'd1) begin bad++; $display("FAIL combo_setup got=%0d/%0d want=0/1", load_id, save_id); end
        base = pulse_cnt;
        key_save_n = 1'b0;
        tick(7);
        total++; if (save_id !== 2'd2) begin bad++; $display("FAIL combo_save_step got=%0d want=2", save_id); end
        tick(3);
        key_load_n = 1'b0;
        tick(6);
        total++; if (load_id !== 2'd0 || save_id !== 2'd2) begin bad++; $display("FAIL combo_pre got=%0d/%0d want=0/2", load_id, save_id); end
        tick(1);
        total++; if (load_id !== 2'd0) begin bad++; $display("FAIL combo_load got=%0d want=0", load_id); end
        total++; if (save_id !== 2'd0) begin bad++; $display("FAIL combo_save got=%0d want=0", save_id); end
        total++; if (changed !== 1'b1) begin bad++; $display("FAIL combo_pulse got=%0b want=1", changed); end
        tick(1);
        total++; if (changed !== 1'b0) begin bad++; $display("FAIL combo_pulse_end got=%0b want=0", changed); end
        tick(2);
        key_load_n = 1'b1; key_save_n = 1'b1;
        tick(20);
        total++; if (load_id !== 2'd0 || save_id !== 2'd0) begin bad++; $display("FAIL combo_after got=%0d/%0d want=0/0", load_id, save_id); end
        total++; if (pulse_cnt - base !== 2) begin bad++; $display("FAIL combo_count got=%0d want=2", pulse_cnt - base); end
    endtask

    task automatic test_both_same();
        int base;
        press(1'b0, 20);  // load 0 -> 1
        press(1'b1, 20);  // save 0 -> 1
        total++; if (load_id !== 2'd1 || save_id !== 2'd1) begin bad++; $display("FAIL same_setup got=%0d/%0d want=1/1", load_id, save_id); end
        base = pulse_cnt;
        key_load_n = 1'b0; key_save_n = 1'b0;
        tick(7);
        total++; if (load_id !== 2'd0 || save_id !== 2'd0) begin bad++; $display("FAIL same_clear got=%0d/%0d want=0/0", load_id, save_id); end
        total++; if (changed !== 1'b1) begin bad++; $display("FAIL same_pulse got=%0b want=1", changed); end
        tick(13);
        key_load_n = 1'b1; key_save_n = 1'b1;
        tick(15);
        total++; if (pulse_cnt - base !== 1) begin bad++; $display("FAIL same_count got=%0d want=1", pulse_cnt - base); end
    endtask

    task automatic test_hold_long();
        int base;
        base = pulse_cnt;
        key_save_n = 1'b0;
        tick(7);
        total++; if (save_id !== 2'd1) begin bad++; $display("FAIL hold_first got=%0d want=1", save_id); end
`ifdef MODE_KEYS_AUTOREPEAT_EN
        tick(19);
        total++; if (save_id !== 2'd1) begin bad++; $display("FAIL rep_early got=%0d want=1", save_id); end
        tick(1);
        total++; if (save_id !== 2'd2) begin bad++; $display("FAIL rep_first got=%0d want=2", save_id); end
        tick(8);
        total++; if (save_id !== 2'd0) begin bad++; $display("FAIL rep_second got=%0d want=0", save_id); end
        tick(8);
        total++; if (save_id !== 2'd1) begin bad++; $display("FAIL rep_third got=%0d want=1", save_id); end
        tick(7);
        key_save_n = 1'b1;
        tick(1);
        total++; if (save_id !== 2'd2) begin bad++; $display("FAIL rep_fourth got=%0d want=2", save_id); end
        tick(20);
        total++; if (save_id !== 2'd2) begin bad++; $display("FAIL rep_final got=%0d want=2", save_id); end
        total++; if (pulse_cnt - base !== 5) begin bad++; $display("FAIL rep_count got=%0d want=5", pulse_cnt - base); end
`else
        tick(43);
        key_save_n = 1'b1;
        tick(20);
        total++; if (save_id !== 2'd1) begin bad++; $display("FAIL hold_final got=%0d want=1", save_id); end
        total++; if (pulse_cnt - base !== 1) begin bad++; $display("FAIL hold_count got=%0d want=1", pulse_cnt - base); end
`endif
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_save_wrap();
        test_async_reset();
        test_glitch_bounce();
        test_combo_hold();
        test_both_same();
        test_hold_long();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
